// File: rtl/fs32_pkg.sv
// Shared types and default sizing for the sequential 32-bit subtractor.
// NSLICE/CNT_W describe the default configuration; the top derives its own from its parameters.
package fs32_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_SLICE = 4;
   localparam int unsigned NSLICE    = DEF_WIDTH / DEF_SLICE;
   localparam int unsigned CNT_W     = $clog2(NSLICE);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/fa_slice.sv
// SLICE-bit combinational ripple-carry full adder, reused once per cycle by fs32_seq.
module fa_slice
   import fs32_pkg::*;
#(
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout
);

   logic [SLICE:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < SLICE; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[SLICE];

endmodule

// File: rtl/fs32_seq.sv
// Sequential subtractor: diff = a - b - bin computed as a + ~b + ~bin, SLICE bits per clock,
// with valid/ready handshakes on both sides. WIDTH must be a multiple of SLICE.
module fs32_seq
   import fs32_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int unsigned NS = WIDTH / SLICE;
   localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NS - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] nb_q, nb_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic [SLICE-1:0] a_sl, nb_sl, sum_sl;
   logic             cout_sl;

   assign a_sl  = a_q[cnt_q*SLICE +: SLICE];
   assign nb_sl = nb_q[cnt_q*SLICE +: SLICE];

   fa_slice #(
      .SLICE(SLICE)
   ) u_fa_slice (
      .a   (a_sl),
      .b   (nb_sl),
      .cin (carry_q),
      .sum (sum_sl),
      .cout(cout_sl)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      nb_d    = nb_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               nb_d    = ~b;
               carry_d = ~bin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            diff_d[cnt_q*SLICE +: SLICE] = sum_sl;
            carry_d = cout_sl;
            if (cnt_q == LAST) begin
               // Final carry is the inverted borrow; a and ~b having equal MSBs means a, b differ.
               bout_d  = ~cout_sl;
               ovf_d   = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sum_sl[SLICE-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         nb_q    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         nb_q    <= nb_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_fs32_seq.sv
// Directed self-checking bench for fs32_seq with an exhaustive corner sweep against a reference model.
module tb_fs32_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_s;
   logic [31:0] b_s;
   logic        bin_s;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        bout;
   logic        ovf;

   int n_assert = 0;
   int n_fail   = 0;

   fs32_seq #(
      .WIDTH(32),
      .SLICE(4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a_s),
      .b        (b_s),
      .bin      (bin_s),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff     (diff),
      .bout     (bout),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for out_valid; returns the number of edges after the accept edge.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   // exp packs {bout, ovf, diff}.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tbin, input logic [33:0] exp);
      int lat;
      a_s      = ta;
      b_s      = tb;
      bin_s    = tbin;
      in_valid = 1'b1;
      check({tag, "_in_ready"}, {33'b0, in_ready}, 34'd1);
      step();
      in_valid = 1'b0;
      wait_valid(lat);
      check({tag, "_latency"}, 34'(lat), 34'd8);
      check({tag, "_result"}, {bout, ovf, diff}, exp);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_after_xfer"}, {32'b0, out_valid, in_ready}, 34'b01);
   endtask

   function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic mbin);
      logic [32:0] r;
      logic        o;
      r = {1'b0, ma} - {1'b0, mb} - {32'b0, mbin};
      o = (ma[31] != mb[31]) && (r[31] != ma[31]);
      return {r[32], o, r[31:0]};
   endfunction

   initial begin
      logic [31:0] vals [30];
      logic [31:0] held;
      int          lat;
      bit          seen;

      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      a_s       = 32'hDEADBEEF;
      b_s       = 32'h1;
      bin_s     = 1'b0;
      step();
      step();
      check("reset_state", {out_valid, in_ready, bout, ovf, diff[29:0]}, {4'b0100, 30'b0});
      check("reset_diff", {2'b0, diff}, 34'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();
      check("idle_after_reset", {32'b0, out_valid, in_ready}, 34'b01);

      run_op("v5m3",   32'h00000005, 32'h00000003, 1'b0, {1'b0, 1'b0, 32'h00000002});
      run_op("v0m1",   32'h00000000, 32'h00000001, 1'b0, {1'b1, 1'b0, 32'hFFFFFFFF});
      run_op("vffbin", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {1'b1, 1'b0, 32'hFFFFFFFF});
      run_op("vneg",   32'h80000000, 32'h00000001, 1'b0, {1'b0, 1'b1, 32'h7FFFFFFF});
      run_op("vpos",   32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, {1'b1, 1'b1, 32'h80000000});

      // Backpressure: new operands held on the input throughout RUN and DONE must be ignored.
      a_s      = 32'h12345678;
      b_s      = 32'h11111111;
      bin_s    = 1'b0;
      in_valid = 1'b1;
      step();
      a_s   = 32'hFFFFFFFF;
      b_s   = 32'h00000000;
      bin_s = 1'b1;
      wait_valid(lat);
      check("bp_latency", 34'(lat), 34'd8);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold", {out_valid, in_ready, diff}, {2'b10, 32'h01234567});
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_result", {bout, ovf, diff}, {2'b00, 32'h01234567});
      step();
      out_ready = 1'b0;
      check("bp_idle", {out_valid, in_ready, diff}, {2'b01, 32'h01234567});
      step();
      check("bp_not_consumed", {out_valid, in_ready, diff}, {2'b01, 32'h01234567});

      // Reset during the 4th RUN cycle aborts the operation.
      a_s      = 32'h0000000A;
      b_s      = 32'h00000001;
      bin_s    = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      check("abort_state", {out_valid, in_ready, diff}, {2'b01, 32'h0});
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      check("abort_no_valid", {33'b0, seen}, 34'd0);

      for (int i = 0; i < 30; i++) begin
         vals[i] = (i < 15) ? 32'(i) : 32'hFFFFFFF0 + 32'(i - 15);
      end
      for (int i = 0; i < 30; i++) begin
         for (int j = 0; j < 30; j++) begin
            for (int k = 0; k < 2; k++) begin
               held = vals[i];
               run_op("sweep", held, vals[j], k[0], model(held, vals[j], k[0]));
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
